// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Brief    : SPI mode-0 target. Synchronises the SPI pins into clk, receives
//            MOSI bytes with their DC flag, and shifts a single-byte-buffered
//            transmit stream out on MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target #(
    parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rstn,
    // SPI pins (asynchronous to clk)
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    // receive stream
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_first,
    output logic       rx_valid,
    // transmit stream
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    input  logic       clr_underrun,
    // status
    output logic       selected
);

    // ------------------------------------------------------------------------
    // Pin synchronisers (two flops each, identical delay on every pin)
    // ------------------------------------------------------------------------
    logic [1:0] sclk_sync_q;
    logic [1:0] cs_n_sync_q;
    logic [1:0] mosi_sync_q;
    logic [1:0] dc_sync_q;
    logic       sclk_prev_q;
    logic       cs_n_prev_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sclk_sync_q <= 2'b00;
            cs_n_sync_q <= 2'b11;
            mosi_sync_q <= 2'b00;
            dc_sync_q   <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_n_prev_q <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            cs_n_sync_q <= {cs_n_sync_q[0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            dc_sync_q   <= {dc_sync_q[0], spi_dc};
            sclk_prev_q <= sclk_sync_q[1];
            cs_n_prev_q <= cs_n_sync_q[1];
        end
    end

    logic sclk_s;
    logic mosi_s;
    logic dc_s;
    logic sel;
    logic rise;
    logic fall;
    logic cs_fall;

    assign sclk_s  = sclk_sync_q[1];
    assign mosi_s  = mosi_sync_q[1];
    assign dc_s    = dc_sync_q[1];
    assign sel     = ~cs_n_sync_q[1];
    assign rise    = sel &  sclk_s & ~sclk_prev_q;
    assign fall    = sel & ~sclk_s &  sclk_prev_q;
    assign cs_fall = cs_n_prev_q & ~cs_n_sync_q[1];

    // ------------------------------------------------------------------------
    // Shift engine and transmit buffer
    // ------------------------------------------------------------------------
    logic [2:0] bit_cnt_q,       bit_cnt_d;
    logic [6:0] rx_shift_q,      rx_shift_d;
    logic [7:0] tx_shift_q,      tx_shift_d;
    logic [7:0] tx_buf_q,        tx_buf_d;
    logic       tx_full_q,       tx_full_d;
    logic       first_pending_q, first_pending_d;
    logic [7:0] rx_data_q,       rx_data_d;
    logic       rx_dc_q,         rx_dc_d;
    logic       rx_first_q,      rx_first_d;
    logic       rx_valid_q,      rx_valid_d;
    logic       tx_underrun_q,   tx_underrun_d;
    logic       slot_load;

    always_comb begin
        bit_cnt_d       = bit_cnt_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        tx_buf_d        = tx_buf_q;
        tx_full_d       = tx_full_q;
        first_pending_d = first_pending_q;
        rx_data_d       = rx_data_q;
        rx_dc_d         = rx_dc_q;
        rx_first_d      = rx_first_q;
        rx_valid_d      = 1'b0;
        tx_underrun_d   = tx_underrun_q;
        slot_load       = 1'b0;

        if (clr_underrun) begin
            tx_underrun_d = 1'b0;
        end

        if (tx_valid && !tx_full_q) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end

        if (!sel) begin
            // Deselected: any partial byte is dropped.
            bit_cnt_d = 3'd0;
        end else if (cs_fall) begin
            bit_cnt_d       = 3'd0;
            first_pending_d = 1'b1;
            slot_load       = 1'b1;
        end else if (rise) begin
            rx_shift_d = {rx_shift_q[5:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                rx_data_d       = {rx_shift_q, mosi_s};
                rx_dc_d         = dc_s;
                rx_first_d      = first_pending_q;
                first_pending_d = 1'b0;
                rx_valid_d      = 1'b1;
            end
        end else if (fall) begin
            if (bit_cnt_q == 3'd0) begin
                slot_load = 1'b1;
            end else begin
                tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
        end

        // A load only consumes a full buffer and a write only fills an empty
        // one, so the two tx_full updates above and below never both apply.
        if (slot_load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_buf_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d    = UNDERRUN_BYTE;
                tx_underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bit_cnt_q       <= 3'd0;
            rx_shift_q      <= 7'd0;
            tx_shift_q      <= UNDERRUN_BYTE;
            tx_buf_q        <= 8'd0;
            tx_full_q       <= 1'b0;
            first_pending_q <= 1'b0;
            rx_data_q       <= 8'd0;
            rx_dc_q         <= 1'b0;
            rx_first_q      <= 1'b0;
            rx_valid_q      <= 1'b0;
            tx_underrun_q   <= 1'b0;
        end else begin
            bit_cnt_q       <= bit_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            tx_buf_q        <= tx_buf_d;
            tx_full_q       <= tx_full_d;
            first_pending_q <= first_pending_d;
            rx_data_q       <= rx_data_d;
            rx_dc_q         <= rx_dc_d;
            rx_first_q      <= rx_first_d;
            rx_valid_q      <= rx_valid_d;
            tx_underrun_q   <= tx_underrun_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign spi_miso    = tx_shift_q[7];
    assign spi_miso_oe = sel;
    assign selected    = sel;
    assign rx_data     = rx_data_q;
    assign rx_dc       = rx_dc_q;
    assign rx_first    = rx_first_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~tx_full_q;
    assign tx_underrun = tx_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_target
// Brief    : Self-checking bench for spi_target: a pin-level SPI controller
//            driving randomized sessions against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_target;

    logic       clk = 1'b0;
    logic       rstn;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_dc;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_first;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_underrun;
    logic       clr_underrun;
    logic       selected;

    always #5 clk = ~clk;

    spi_target #(.UNDERRUN_BYTE(8'hFF)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .spi_dc       (spi_dc),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .rx_data      (rx_data),
        .rx_dc        (rx_dc),
        .rx_first     (rx_first),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_underrun  (tx_underrun),
        .clr_underrun (clr_underrun),
        .selected     (selected)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model of the transmit buffer and underrun flag
    logic       m_full;
    logic [7:0] m_buf;
    logic       m_underrun;

    task automatic m_load(output logic [7:0] b);
        if (m_full) begin
            b      = m_buf;
            m_full = 1'b0;
        end else begin
            b          = 8'hFF;
            m_underrun = 1'b1;
        end
    endtask

    // Received-byte capture: {first, dc, data}
    logic [9:0] got_rx[$];
    logic [9:0] exp_rx[$];

    always @(negedge clk) begin
        if (rx_valid === 1'b1) got_rx.push_back({rx_first, rx_dc, rx_data});
    end

    // Session description
    logic [7:0] s_data [8];
    logic       s_dc   [8];
    logic       s_wr   [8];
    logic [7:0] s_wdata[8];
    logic       s_wr_pre;
    logic [7:0] s_wdata_pre;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_sess();
        for (int i = 0; i < 8; i++) begin
            s_data[i] = 8'h00; s_dc[i] = 1'b0; s_wr[i] = 1'b0; s_wdata[i] = 8'h00;
        end
        s_wr_pre    = 1'b0;
        s_wdata_pre = 8'h00;
    endtask

    task automatic write_tx(input logic [7:0] b);
        int waited = 0;
        while (tx_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("tx_ready_before_write", tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        m_full   = 1'b1;
        m_buf    = b;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        m_underrun   = 1'b0;
        wait_clk(1);
        check("underrun_cleared", tx_underrun, 1'b0);
    endtask

    task automatic check_rx();
        check("rx_count", got_rx.size(), exp_rx.size());
        for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++)
            check($sformatf("rx_byte%0d", i), got_rx[i], exp_rx[i]);
        got_rx.delete();
        exp_rx.delete();
    endtask

    // One CS-framed session of n bytes; the last byte may be cut short.
    task automatic run_session(input int n, input int last_bits, input int half, input bit do_rst);
        logic [7:0] exp_b;
        logic [7:0] got_b;
        int         nb;
        if (s_wr_pre && !m_full) write_tx(s_wdata_pre);
        @(negedge clk);
        spi_cs_n = 1'b0;
        spi_dc   = s_dc[0];
        spi_mosi = s_data[0][7];
        m_load(exp_b);
        wait_clk(3);
        check("miso_oe_selected", spi_miso_oe, 1'b1);
        check("selected", selected, 1'b1);
        for (int b = 0; b < n; b++) begin
            nb    = (b == n - 1) ? last_bits : 8;
            got_b = 8'h00;
            for (int k = 0; k < nb; k++) begin
                spi_mosi = s_data[b][7-k];
                spi_dc   = s_dc[b];
                wait_clk(half);
                got_b[7-k] = spi_miso;
                spi_sclk = 1'b1;
                wait_clk(half);
                spi_sclk = 1'b0;
                if (k == 3 && s_wr[b] && !m_full) write_tx(s_wdata[b]);
            end
            if (nb == 8) begin
                check($sformatf("miso_byte%0d", b), got_b, exp_b);
                exp_rx.push_back({(b == 0), s_dc[b], s_data[b]});
                m_load(exp_b);
            end
        end
        if (do_rst) begin
            rstn = 1'b0;
            wait_clk(3);
            check("rst_miso", spi_miso, 1'b1);
            check("rst_miso_oe", spi_miso_oe, 1'b0);
            check("rst_rx_data", rx_data, 8'h00);
            check("rst_rx_dc", rx_dc, 1'b0);
            check("rst_rx_first", rx_first, 1'b0);
            check("rst_rx_valid", rx_valid, 1'b0);
            check("rst_tx_ready", tx_ready, 1'b1);
            check("rst_underrun", tx_underrun, 1'b0);
            check("rst_selected", selected, 1'b0);
            spi_cs_n = 1'b1;
            spi_sclk = 1'b0;
            wait_clk(3);
            rstn       = 1'b1;
            m_full     = 1'b0;
            m_underrun = 1'b0;
        end else begin
            wait_clk(half);
            spi_cs_n = 1'b1;
        end
        wait_clk(6);
        check_rx();
        check("underrun", tx_underrun, m_underrun);
        check("tx_ready", tx_ready, !m_full);
        check("miso_oe_idle", spi_miso_oe, 1'b0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] dummy;
        int         n;
        int         lb;
        rstn = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; spi_dc = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; clr_underrun = 1'b0;
        m_full = 1'b0; m_buf = 8'h00; m_underrun = 1'b0;
        clear_sess();
        wait_clk(4);
        rstn = 1'b1;
        wait_clk(2);

        // Reset state and idle SCK activity with CS deasserted
        check("init_miso", spi_miso, 1'b1);
        check("init_miso_oe", spi_miso_oe, 1'b0);
        check("init_rx_data", rx_data, 8'h00);
        check("init_tx_ready", tx_ready, 1'b1);
        check("init_underrun", tx_underrun, 1'b0);
        check("init_selected", selected, 1'b0);
        for (int i = 0; i < 16; i++) begin
            spi_mosi = i[0];
            spi_sclk = 1'b1; wait_clk(3);
            spi_sclk = 1'b0; wait_clk(3);
        end
        wait_clk(4);
        check_rx();
        check("idle_miso_oe", spi_miso_oe, 1'b0);

        // Single byte with a pre-written transmit byte
        clear_sess();
        s_wr_pre = 1'b1; s_wdata_pre = 8'hA5;
        s_data[0] = 8'h3C; s_dc[0] = 1'b1;
        run_session(1, 8, 3, 1'b0);
        clr_pulse();

        // Three-byte burst with writes during the transfer
        clear_sess();
        s_wr_pre = 1'b1; s_wdata_pre = 8'h10;
        s_data[0] = 8'h01; s_data[1] = 8'h02; s_data[2] = 8'h03;
        s_wr[0] = 1'b1; s_wdata[0] = 8'h20;
        s_wr[1] = 1'b1; s_wdata[1] = 8'h30;
        s_wr[2] = 1'b1; s_wdata[2] = 8'h40;
        run_session(3, 8, 3, 1'b0);

        // Underrun, clear, and clear colliding with a new underrun
        clear_sess();
        s_data[0] = 8'h77;
        run_session(1, 8, 3, 1'b0);
        clr_pulse();
        @(negedge clk);
        spi_cs_n = 1'b0;
        wait_clk(2);
        clr_underrun = 1'b1;
        wait_clk(1);
        clr_underrun = 1'b0;
        m_load(dummy);
        wait_clk(3);
        check("underrun_beats_clear", tx_underrun, 1'b1);
        spi_cs_n = 1'b1;
        wait_clk(6);
        clr_pulse();

        // Aborted partial byte followed by a full byte
        clear_sess();
        s_data[0] = 8'hF0;
        run_session(1, 4, 3, 1'b0);
        clear_sess();
        s_data[0] = 8'h5A;
        run_session(1, 8, 4, 1'b0);

        // Reset mid-byte, then a clean byte
        clear_sess();
        s_wr_pre = 1'b1; s_wdata_pre = 8'h11;
        s_data[0] = 8'h96; s_dc[0] = 1'b1;
        s_data[1] = 8'hE7; s_wr[1] = 1'b1; s_wdata[1] = 8'h22;
        run_session(2, 4, 3, 1'b1);
        clear_sess();
        s_wr_pre = 1'b1; s_wdata_pre = 8'h3E;
        s_data[0] = 8'hC3;
        run_session(1, 8, 3, 1'b0);

        // Randomized sessions
        for (int it = 0; it < 30; it++) begin
            clear_sess();
            n  = $urandom_range(1, 4);
            lb = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 8;
            s_wr_pre    = $urandom_range(0, 1) == 1;
            s_wdata_pre = 8'($urandom);
            for (int b = 0; b < n; b++) begin
                s_data[b]  = 8'($urandom);
                s_dc[b]    = $urandom_range(0, 1) == 1;
                s_wr[b]    = $urandom_range(0, 3) != 0;
                s_wdata[b] = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) clr_pulse();
            run_session(n, lb, $urandom_range(3, 5), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_target.md
# spi_target

SPI mode-0 target (peripheral) that sits at the far end of the SoC's SPI controller link: external SPI pins in, byte stream out. It synchronises SCK/CS/MOSI/DC into the `clk` domain, deserialises MOSI bytes with their DC flag, and serialises a single-byte-buffered transmit stream onto MISO. It is used for board-to-board links and in loopback testing of the SPI controller.

## Interface
Parameters:
- `UNDERRUN_BYTE`, default 8'hFF: byte shifted out when no transmit byte is buffered.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  synchronous, active-low reset.
- `spi_sclk`  in  1  async SPI clock, idle low.
- `spi_cs_n`  in  1  async chip select, active low.
- `spi_mosi`  in  1  async data from controller.
- `spi_dc`  in  1  async data/command flag.
- `spi_miso`  out  1  serial data to controller.
- `spi_miso_oe`  out  1  MISO output enable; high while selected.
- `rx_data`  out  8  last received byte; held until next byte completes.
- `rx_dc`  out  1  DC level sampled with bit 0 of `rx_data`.
- `rx_first`  out  1  `rx_data` is the first byte since CS asserted.
- `rx_valid`  out  1  one-cycle pulse when `rx_data`/`rx_dc`/`rx_first` update.
- `tx_data`  in  8  byte to transmit.
- `tx_valid`  in  1  offer `tx_data`.
- `tx_ready`  out  1  transmit buffer empty; transfer occurs on `tx_valid & tx_ready`.
- `tx_underrun`  out  1  sticky: a byte slot started with an empty buffer.
- `clr_underrun`  in  1  clears `tx_underrun`; a new underrun in the same cycle wins.
- `selected`  out  1  synchronised CS active.

## Operation
- Synchronisers: 2-flop on `spi_sclk`, `spi_cs_n`, `spi_mosi` and `spi_dc`, all with equal delay. Reset values: SCK 0, CS_n 1, MOSI 0, DC 0. `sclk_prev` tracks synced SCK.
- `rise` = synced SCK 0→1 while selected. `fall` = 1→0 while selected. `cs_fall` = synced CS_n 1→0.
- State: `bit_cnt[2:0]`, `rx_shift[6:0]`, `tx_shift[7:0]`, `tx_buf[7:0]`, `tx_full`, `first_pending`.
- `cs_fall`: `bit_cnt`←0; `first_pending`←1; load byte slot.
- Load byte slot: if `tx_full`, `tx_shift`←`tx_buf` and `tx_full`←0. Otherwise `tx_shift`←`UNDERRUN_BYTE` and `tx_underrun`←1.
- `rise`: `rx_shift`←{`rx_shift[5:0]`, mosi}; `bit_cnt`++ (wraps at 8).
  - When `bit_cnt`==7 before the increment: `rx_data`←{`rx_shift`, mosi}; `rx_dc`←dc; `rx_first`←`first_pending`; `first_pending`←0; pulse `rx_valid`.
- `fall`: if `bit_cnt`==0, a byte has just completed, so load the next byte slot. Otherwise `tx_shift`←{`tx_shift[6:0]`, 0}.
- `spi_miso` = `tx_shift[7]`; `spi_miso_oe` = `selected`.
- CS deasserted (synced) mid-byte: partial byte discarded, no `rx_valid`, `bit_cnt`←0. Edges are ignored while deselected. `tx_buf`/`tx_full` are retained; the in-flight `tx_shift` byte is lost.
- `tx_ready` = !`tx_full`. A write and a slot load never collide: a load only consumes a full buffer, and a write only fills an empty one.
- Reset, including mid-transfer: all state cleared. `tx_shift`←`UNDERRUN_BYTE`, `tx_full`←0, `tx_underrun`←0, `bit_cnt`←0, `first_pending`←0.

## Timing
- Reset values: `spi_miso`=`UNDERRUN_BYTE[7]`, `spi_miso_oe`=0, `rx_data`=0, `rx_dc`=0, `rx_first`=0, `rx_valid`=0, `tx_ready`=1, `tx_underrun`=0, `selected`=0.
- Pin-to-internal latency: 2 clk for synchronisation, plus 1 clk for edge detect.
- `rx_valid` asserts 3 clk after the 8th SCK rising edge at the pin.
- MISO updates 3 clk after the SCK falling edge at the pin. After CS assertion at the pin, the first bit is valid 3 clk later.
- Requirement: SCK half-period ≥ 3 clk, i.e. the controller divider setting ≥ 2 (SCK ≤ clk/6). CS-to-first-SCK-rise ≥ 3 clk.
- `tx_valid` must be presented before the 8th SCK falling edge of the current byte to avoid an underrun on the next byte; once written, the byte is ready for the next slot.
- `rx_valid` is a single-cycle pulse with no back-pressure; the consumer must capture it in that cycle.

## Test plan
- Reset, then idle: `tx_ready`=1, `spi_miso_oe`=0, no `rx_valid` pulses with SCK toggling while CS_n=1.
- Write `tx_data`=8'hA5. Controller (divider 2) sends 8'h3C with DC=1, CS held. Expect `rx_valid` once with `rx_data`=8'h3C, `rx_dc`=1, `rx_first`=1; controller reads 8'hA5; `tx_ready` returns to 1 at the slot load.
- Three-byte burst 8'h01, 8'h02, 8'h03, with 8'h10/8'h20/8'h30 written during transfer. Expect three `rx_valid` pulses with `rx_first`=1,0,0; controller reads 10,20,30; `tx_underrun`=0.
- No tx write, one byte transfer. Expect the controller to read 8'hFF and `tx_underrun`=1. Pulse `clr_underrun` → 0. Assert `clr_underrun` in the same cycle as a new underrun → remains 1.
- CS_n deasserted after 4 bits of 8'hF0, then a full byte 8'h5A. Expect only one `rx_valid`, with `rx_data`=8'h5A and `rx_first`=1.
- Assert `rstn` low mid-byte. Expect all outputs at reset values; the next full byte is received correctly.
